branch_ctrl: RTL and testbench

Branch resolution stage in the ID stage of the 16-bit pipeline. It sits directly downstream of the branch-type decoder. It takes the decoded 2-bit branch type, the forwarded source operand and the sign-extended offset, and decides taken or not-taken. For a taken branch it drives a registered, one-shot PC redirect and an IF/ID flush, so the delay-slot instruction still executes and the wrongly fetched instruction after it is killed. It also keeps saturating branch and taken counters for performance inspection.

---
 rtl/branch_ctrl.sv | 114 +++++++++++
 tb/tb_branch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution for the ID stage: decides taken/not-taken, then drives a
// one-shot registered PC redirect plus IF/ID flush, and counts branches.
module branch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        is_branch,
  input  logic [1:0]  jorb,
  input  logic [15:0] src_val,
  input  logic [15:0] id_pc,
  input  logic [15:0] imm,
  output logic        redirect,
  output logic [15:0] pc_target,
  output logic        flush_ifid,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_e;

  localparam logic [1:0] JORB_B    = 2'b00;
  localparam logic [1:0] JORB_JR   = 2'b01;
  localparam logic [1:0] JORB_BEQZ = 2'b10;
  localparam logic [1:0] JORB_BNEZ = 2'b11;

  state_e      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic        accept;
  logic        src_zero;
  logic        taken;
  logic [15:0] br_target;

  // Decision logic: a branch is only looked at while IDLE, so a branch
  // sitting in the delay slot during REDIRECT is ignored.
  always_comb begin
    accept   = (state_q == S_IDLE) & id_valid & is_branch & ~stall;
    src_zero = (src_val == 16'h0000);
    taken    = 1'b0;
    unique case (jorb)
      JORB_B:    taken = 1'b1;
      JORB_JR:   taken = 1'b1;
      JORB_BEQZ: taken = src_zero;
      JORB_BNEZ: taken = ~src_zero;
      default:   taken = 1'b0;
    endcase
    if (jorb == JORB_JR) begin
      br_target = src_val;
    end else begin
      br_target = id_pc + imm;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_q     <= 16'h0000;
      branch_cnt_q <= 16'h0000;
      taken_cnt_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  // Next-state logic; target and counters change only on an accepted branch.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (branch_cnt_q != 16'hFFFF) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
          end
          if (taken) begin
            state_d  = S_REDIRECT;
            target_d = br_target;
            if (taken_cnt_q != 16'hFFFF) begin
              taken_cnt_d = taken_cnt_q + 16'd1;
            end
          end
        end
      end
      S_REDIRECT: begin
        if (!stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state, so reset clears them at once.
  always_comb begin
    redirect   = (state_q == S_REDIRECT);
    flush_ifid = (state_q == S_REDIRECT);
    pc_target  = target_q;
    branch_cnt = branch_cnt_q;
    taken_cnt  = taken_cnt_q;
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a per-cycle reference model compared on
// every falling edge, plus literal checks of the documented scenarios.
module tb_branch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        id_valid;
  logic        is_branch;
  logic [1:0]  jorb;
  logic [15:0] src_val;
  logic [15:0] id_pc;
  logic [15:0] imm;
  logic        redirect;
  logic [15:0] pc_target;
  logic        flush_ifid;
  logic [15:0] branch_cnt;
  logic [15:0] taken_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  branch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .id_valid  (id_valid),
    .is_branch (is_branch),
    .jorb      (jorb),
    .src_val   (src_val),
    .id_pc     (id_pc),
    .imm       (imm),
    .redirect  (redirect),
    .pc_target (pc_target),
    .flush_ifid(flush_ifid),
    .branch_cnt(branch_cnt),
    .taken_cnt (taken_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a redirect is owed for the cycle after an accepted taken
  // branch, and keeps being owed for as long as stall is held.
  int m_redir;
  int m_target;
  int m_bcnt;
  int m_tcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_redir  = 0;
      m_target = 0;
      m_bcnt   = 0;
      m_tcnt   = 0;
    end else if (m_redir != 0) begin
      if (!stall) m_redir = 0;
    end else if (id_valid && is_branch && !stall) begin
      bit tk;
      tk = (jorb == 2'd0) || (jorb == 2'd1) ||
           (jorb == 2'd2 && src_val == 0) || (jorb == 2'd3 && src_val != 0);
      m_bcnt = (m_bcnt + 1 > 65535) ? 65535 : m_bcnt + 1;
      if (tk) begin
        m_tcnt   = (m_tcnt + 1 > 65535) ? 65535 : m_tcnt + 1;
        m_redir  = 1;
        m_target = (jorb == 2'd1) ? int'(src_val) : (int'(id_pc) + int'(imm)) % 65536;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("redirect",   {15'd0, redirect},   16'(m_redir));
    chk("flush_ifid", {15'd0, flush_ifid}, 16'(m_redir));
    chk("pc_target",  pc_target,           16'(m_target));
    chk("branch_cnt", branch_cnt,          16'(m_bcnt));
    chk("taken_cnt",  taken_cnt,           16'(m_tcnt));
  end

  // Driver tasks
  task automatic drive(input logic v, input logic b, input logic [1:0] j,
                       input logic [15:0] s, input logic [15:0] pc,
                       input logic [15:0] im, input logic st);
    id_valid  = v;
    is_branch = b;
    jorb      = j;
    src_val   = s;
    id_pc     = pc;
    imm       = im;
    stall     = st;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("rst_redirect", {15'd0, redirect}, 16'h0000);
    chk("rst_target",   pc_target,         16'h0000);
    chk("rst_bcnt",     branch_cnt,        16'h0000);
    step();
    rst = 1'b0;
    step();

    // Taken BEQZ with negative offset
    drive(1'b1, 1'b1, 2'b10, 16'h0000, 16'h0011, 16'hFFFE, 1'b0);
    step();
    idle();
    #1;
    chk("beqz_redirect", {15'd0, redirect},   16'h0001);
    chk("beqz_flush",    {15'd0, flush_ifid}, 16'h0001);
    chk("beqz_target",   pc_target,           16'h000F);
    chk("beqz_bcnt",     branch_cnt,          16'h0001);
    chk("beqz_tcnt",     taken_cnt,           16'h0001);
    step();
    chk("beqz_done", {15'd0, redirect}, 16'h0000);

    // Not-taken BNEZ: zero penalty, only branch_cnt moves
    drive(1'b1, 1'b1, 2'b11, 16'h0000, 16'h0040, 16'h0010, 1'b0);
    step();
    idle();
    chk("bnez_redirect", {15'd0, redirect}, 16'h0000);
    chk("bnez_bcnt",     branch_cnt,        16'h0002);
    chk("bnez_tcnt",     taken_cnt,         16'h0001);

    // Taken BNEZ and not-taken BEQZ with a nonzero operand
    drive(1'b1, 1'b1, 2'b11, 16'h0004, 16'h0200, 16'h0020, 1'b0);
    step();
    idle();
    chk("bnez_tk_target", pc_target, 16'h0220);
    step();
    drive(1'b1, 1'b1, 2'b10, 16'h0004, 16'h0300, 16'h0020, 1'b0);
    step();
    idle();
    chk("beqz_nt_redirect", {15'd0, redirect}, 16'h0000);

    // JR then B with wrap-around target
    drive(1'b1, 1'b1, 2'b01, 16'h8000, 16'h1234, 16'h0777, 1'b0);
    step();
    idle();
    chk("jr_target", pc_target, 16'h8000);
    step();
    drive(1'b1, 1'b1, 2'b00, 16'h5555, 16'hFFFF, 16'h0002, 1'b0);
    step();
    idle();
    chk("b_wrap_target", pc_target, 16'h0001);
    step();

    // Non-branch and bubble traffic must not count
    drive(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0010, 16'h0001, 1'b0);
    step();
    drive(1'b0, 1'b1, 2'b00, 16'h0000, 16'h0010, 16'h0001, 1'b0);
    step();
    chk("nonbr_bcnt", branch_cnt, 16'h0006);

    // Stall during decision blocks acceptance; re-evaluated with later operands
    drive(1'b1, 1'b1, 2'b10, 16'h0000, 16'h0050, 16'h0001, 1'b1);
    step();
    chk("stall_n_redirect", {15'd0, redirect}, 16'h0000);
    drive(1'b1, 1'b1, 2'b10, 16'h0001, 16'h0050, 16'h0001, 1'b0);
    step();
    idle();
    chk("stall_n_nt", {15'd0, redirect}, 16'h0000);
    chk("stall_n_bcnt", branch_cnt, 16'h0007);

    // Stall in REDIRECT for 3 cycles with a branch in the delay slot
    drive(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0100, 16'h0005, 1'b0);
    step();
    drive(1'b1, 1'b1, 2'b01, 16'h9999, 16'h0000, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_redirect", {15'd0, redirect}, 16'h0001);
      chk("stall_target",   pc_target,         16'h0105);
      step();
    end
    stall = 1'b0;
    chk("stall_redirect4", {15'd0, redirect}, 16'h0001);
    chk("stall_target4",   pc_target,         16'h0105);
    step();
    idle();
    chk("stall_done", {15'd0, redirect}, 16'h0000);
    chk("stall_bcnt", branch_cnt,        16'h0008);
    chk("stall_tcnt", taken_cnt,         16'h0005);

    // Asynchronous reset mid-redirect
    drive(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0700, 16'h0010, 1'b0);
    step();
    idle();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_redirect", {15'd0, redirect},   16'h0000);
    chk("arst_flush",    {15'd0, flush_ifid}, 16'h0000);
    chk("arst_target",   pc_target,           16'h0000);
    chk("arst_tcnt",     taken_cnt,           16'h0000);
    step();
    rst = 1'b0;
    step();
    chk("arst_idle", {15'd0, redirect}, 16'h0000);

    // Saturation: preload both counters near the top, then keep branching
    force dut.branch_cnt_q = 16'hFFFC;
    force dut.taken_cnt_q  = 16'hFFFC;
    #1;
    release dut.branch_cnt_q;
    release dut.taken_cnt_q;
    m_bcnt = 65532;
    m_tcnt = 65532;
    drive(1'b1, 1'b1, 2'b00, 16'h0000, 16'h0020, 16'h0003, 1'b0);
    for (int i = 0; i < 12; i++) step();
    chk("sat_bcnt", branch_cnt, 16'hFFFF);
    chk("sat_tcnt", taken_cnt,  16'hFFFF);
    drive(1'b1, 1'b1, 2'b11, 16'h0000, 16'h0020, 16'h0003, 1'b0);
    for (int i = 0; i < 3; i++) step();
    idle();
    step();
    chk("sat_hold_bcnt", branch_cnt, 16'hFFFF);
    chk("sat_hold_tcnt", taken_cnt,  16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
